led_pwm_fader: RTL and testbench

//   Downstream of the LED pattern generator: takes its NUM_LEDS-bit on/off pattern and drives the board LEDs.

---
 rtl/led_pwm_fader_if.sv | 24 ++
 rtl/led_pwm_fader.sv | 124 ++++++++++++
 tb/tb_led_pwm_fader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/led_pwm_fader_if.sv
// Pattern/enable in, PWM drive and busy out, between the LED pattern generator and the fader.
// master = pattern source, slave = fader.
interface led_pwm_fader_if #(
    parameter int NUM_LEDS = 5
);
    logic [NUM_LEDS-1:0] pattern;
    logic                enable;
    logic [NUM_LEDS-1:0] led;
    logic                busy;

    modport master (
        output pattern,
        output enable,
        input  led,
        input  busy
    );

    modport slave (
        input  pattern,
        input  enable,
        output led,
        output busy
    );
endinterface

// File: rtl/led_pwm_fader.sv
// Per-LED PWM fader: each pattern bit ramps its channel brightness linearly between
// 0 and MAX_LEVEL, one step every STEP_DIV cycles, and drives a registered PWM output.
module led_pwm_fader #(
    parameter int NUM_LEDS  = 5,
    parameter int PWM_BITS  = 8,
    parameter int MAX_LEVEL = 255,
    parameter int STEP_DIV  = 4096
) (
    input  logic           clk,
    input  logic           resetn,
    led_pwm_fader_if.slave bus
);
    localparam int                  PRESC_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX_LVL    = PWM_BITS'(MAX_LEVEL);
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        CH_OFF,
        CH_RAMP_UP,
        CH_ON,
        CH_RAMP_DOWN
    } ch_state_e;

    generate
        if (MAX_LEVEL < 0 || MAX_LEVEL > (2**PWM_BITS - 1)) begin : g_bad_max_level
            $error("led_pwm_fader: MAX_LEVEL must lie in 0..2**PWM_BITS-1");
        end
        if (STEP_DIV < 1) begin : g_bad_step_div
            $error("led_pwm_fader: STEP_DIV must be at least 1");
        end
        if (NUM_LEDS < 1) begin : g_bad_num_leds
            $error("led_pwm_fader: NUM_LEDS must be at least 1");
        end
    endgenerate

    logic [NUM_LEDS-1:0] r_pat_q;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PRESC_W-1:0]  r_presc;
    logic [NUM_LEDS-1:0] r_led;
    logic                r_busy;

    logic [PRESC_W-1:0]  w_presc_next;
    logic                w_step_tick;
    logic [NUM_LEDS-1:0] w_led_next;
    logic [NUM_LEDS-1:0] w_ch_busy;

    // Step prescaler parks at 0 while disabled so a re-enable always starts a full step period.
    always_comb begin
        w_presc_next = r_presc;
        w_step_tick  = 1'b0;
        if (!bus.enable) begin
            w_presc_next = '0;
        end else if (r_presc == PRESC_LAST) begin
            w_presc_next = '0;
            w_step_tick  = 1'b1;
        end else begin
            w_presc_next = r_presc + PRESC_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
            logic [PWM_BITS-1:0] r_level;
            logic [PWM_BITS-1:0] w_target;
            logic [PWM_BITS-1:0] w_level_next;
            ch_state_e           w_state;

            assign w_target = r_pat_q[gi] ? MAX_LVL : '0;

            // Channel state is a pure function of level vs target; level itself is the stored state.
            always_comb begin
                w_state      = CH_OFF;
                w_level_next = r_level;
                if (r_level < w_target) begin
                    w_state = CH_RAMP_UP;
                end else if (r_level > w_target) begin
                    w_state = CH_RAMP_DOWN;
                end else if (w_target != '0) begin
                    w_state = CH_ON;
                end
                if (w_step_tick) begin
                    case (w_state)
                        CH_RAMP_UP:   w_level_next = r_level + PWM_BITS'(1);
                        CH_RAMP_DOWN: w_level_next = r_level - PWM_BITS'(1);
                        default:      w_level_next = r_level;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_level <= '0;
                end else begin
                    r_level <= w_level_next;
                end
            end

            assign w_led_next[gi] = bus.enable & (r_level > r_pwm_cnt);
            // Judged on the next level so busy drops on the same edge the channel arrives.
            assign w_ch_busy[gi]  = (w_level_next != w_target);
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pat_q   <= '0;
            r_pwm_cnt <= '0;
            r_presc   <= '0;
            r_led     <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_pat_q   <= bus.pattern;
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            r_presc   <= w_presc_next;
            r_led     <= w_led_next;
            r_busy    <= |w_ch_busy;
        end
    end

    assign bus.led  = r_led;
    assign bus.busy = r_busy;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader: reset, ramp timing, PWM duty, reversal, enable freeze,
// concurrent channels and async reset mid-ramp.
module tb_led_pwm_fader;
    localparam int NL = 5;

    logic clk = 1'b0;
    logic resetn;
    int   n_assert = 0;
    int   n_fail   = 0;

    led_pwm_fader_if #(.NUM_LEDS(NL)) bus ();
    led_pwm_fader_if #(.NUM_LEDS(1))  bus2 ();

    led_pwm_fader #(
        .NUM_LEDS (NL),
        .PWM_BITS (4),
        .MAX_LEVEL(15),
        .STEP_DIV (2)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    // Second instance: mid-scale MAX_LEVEL gives a steady level of 8 for the duty check.
    led_pwm_fader #(
        .NUM_LEDS (1),
        .PWM_BITS (4),
        .MAX_LEVEL(8),
        .STEP_DIV (1)
    ) dut2 (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int cnt0;
        int cnt1;
        int cnt2;
        int exp_lvl;

        resetn        = 1'b0;
        bus.pattern   = '0;
        bus.enable    = 1'b1;
        bus2.pattern  = 1'b1;
        bus2.enable   = 1'b1;

        // Reset held: pattern wiggles, outputs stay quiet.
        for (int i = 0; i < 6; i++) begin
            bus.pattern = 5'(i * 7);
            tick();
            check("rst_led", 32'(bus.led), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
        end
        check("rst_level0", 32'(dut.g_ch[0].r_level), 32'd0);
        $display("step reset-hold done");

        // Ramp up ch0: steps land on even edges after release.
        bus.pattern = 5'b00001;
        resetn      = 1'b1;
        tick();
        check("up_e1_busy", 32'(bus.busy), 32'd0);
        check("up_e1_level", 32'(dut.g_ch[0].r_level), 32'd0);
        tick();
        check("up_e2_busy", 32'(bus.busy), 32'd1);
        check("up_e2_level", 32'(dut.g_ch[0].r_level), 32'd1);
        for (int n = 3; n <= 29; n++) begin
            tick();
            check("up_level", 32'(dut.g_ch[0].r_level), 32'(n / 2));
            check("up_busy", 32'(bus.busy), 32'd1);
            check("up_other_led", 32'(bus.led[4:1]), 32'd0);
        end
        tick();
        check("up_e30_level", 32'(dut.g_ch[0].r_level), 32'd15);
        check("up_e30_busy", 32'(bus.busy), 32'd0);
        check("up_ch1_level", 32'(dut.g_ch[1].r_level), 32'd0);
        $display("step ramp-up done");

        // Duty: level 15 -> 15/16, level 0 -> never, level 8 (dut2) -> 8/16.
        cnt0 = 0;
        cnt1 = 0;
        cnt2 = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            cnt0 += int'(bus.led[0]);
            cnt1 += int'(bus.led[1]);
            cnt2 += int'(bus2.led[0]);
        end
        check("duty_15", 32'(cnt0), 32'd15);
        check("duty_0", 32'(cnt1), 32'd0);
        check("duty_8", 32'(cnt2), 32'd8);
        check("dut2_busy", 32'(bus2.busy), 32'd0);
        $display("step pwm-duty done");

        // Concurrent channels: 10101, then flip to 01010.
        bus.pattern = 5'b10101;
        cyc = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            cyc++;
            if (cyc >= 2 && !bus.busy) break;
        end
        check("conc_a_settle_30_31", 32'(cyc >= 30 && cyc <= 31), 32'd1);
        check("conc_a_l2", 32'(dut.g_ch[2].r_level), 32'd15);
        check("conc_a_l4", 32'(dut.g_ch[4].r_level), 32'd15);
        check("conc_a_l1", 32'(dut.g_ch[1].r_level), 32'd0);

        bus.pattern = 5'b01010;
        cyc = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            cyc++;
            check("conc_sum01", 32'(dut.g_ch[0].r_level) + 32'(dut.g_ch[1].r_level), 32'd15);
            check("conc_l2_eq_l0", 32'(dut.g_ch[2].r_level), 32'(dut.g_ch[0].r_level));
            check("conc_l4_eq_l0", 32'(dut.g_ch[4].r_level), 32'(dut.g_ch[0].r_level));
            check("conc_l3_eq_l1", 32'(dut.g_ch[3].r_level), 32'(dut.g_ch[1].r_level));
            if (cyc >= 2 && !bus.busy) break;
        end
        check("conc_b_settle_30_31", 32'(cyc >= 30 && cyc <= 31), 32'd1);
        check("conc_b_l0", 32'(dut.g_ch[0].r_level), 32'd0);
        check("conc_b_l1", 32'(dut.g_ch[1].r_level), 32'd15);
        check("conc_b_l3", 32'(dut.g_ch[3].r_level), 32'd15);
        check("conc_b_busy", 32'(bus.busy), 32'd0);
        $display("step concurrent done");

        // Enable freeze at level 7.
        bus.pattern = 5'b01011;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dut.g_ch[0].r_level == 4'd7) break;
        end
        check("en_reach7", 32'(dut.g_ch[0].r_level), 32'd7);
        bus.enable = 1'b0;
        tick();
        check("en_off_led", 32'(bus.led), 32'd0);
        check("en_off_level", 32'(dut.g_ch[0].r_level), 32'd7);
        check("en_off_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("en_hold_level", 32'(dut.g_ch[0].r_level), 32'd7);
            check("en_hold_led", 32'(bus.led), 32'd0);
            check("en_hold_busy", 32'(bus.busy), 32'd1);
        end
        bus.enable = 1'b1;
        tick();
        check("en_resume_e1", 32'(dut.g_ch[0].r_level), 32'd7);
        tick();
        check("en_resume_e2", 32'(dut.g_ch[0].r_level), 32'd8);
        $display("step enable-freeze done");

        // Async reset between edges, mid-ramp.
        #2;
        resetn = 1'b0;
        #1;
        check("arst_led", 32'(bus.led), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_level0", 32'(dut.g_ch[0].r_level), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.pattern = 5'(5'b11111 - 5'(i));
            tick();
            check("arst_hold_led", 32'(bus.led), 32'd0);
            check("arst_hold_busy", 32'(bus.busy), 32'd0);
        end
        $display("step async-reset done");

        // Reversal at level 5: continuous ramp back down.
        bus.pattern = 5'b00001;
        resetn      = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            check("rev_up_level", 32'(dut.g_ch[0].r_level), 32'(n / 2));
        end
        bus.pattern = 5'b00000;
        tick();
        check("rev_e11_level", 32'(dut.g_ch[0].r_level), 32'd5);
        check("rev_e11_busy", 32'(bus.busy), 32'd1);
        tick();
        check("rev_e12_level", 32'(dut.g_ch[0].r_level), 32'd4);
        check("rev_e12_busy", 32'(bus.busy), 32'd1);
        for (int n = 13; n <= 19; n++) begin
            tick();
            exp_lvl = 4 - (n - 12) / 2;
            check("rev_down_level", 32'(dut.g_ch[0].r_level), 32'(exp_lvl));
            check("rev_down_busy", 32'(bus.busy), 32'd1);
        end
        tick();
        check("rev_e20_level", 32'(dut.g_ch[0].r_level), 32'd0);
        check("rev_e20_busy", 32'(bus.busy), 32'd0);
        $display("step reversal done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
